// File: rtl/proc_din_sequencer_if.sv
// Bundles the program-load bus and the lab9 DIN/Run/Done handshake of proc_din_sequencer.
// master = sequencer side, slave = processor/loader side.
interface proc_din_sequencer_if #(
    parameter int unsigned AW = 5
);
    logic          Start;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [8:0]    ld_data;
    logic          Done;
    logic [8:0]    DIN;
    logic          Run;
    logic          Busy;
    logic          Halted;
    logic          Error;
    logic [AW:0]   pc;

    modport master (
        input  Start, ld_we, ld_addr, ld_data, Done,
        output DIN, Run, Busy, Halted, Error, pc
    );

    modport slave (
        output Start, ld_we, ld_addr, ld_data, Done,
        input  DIN, Run, Busy, Halted, Error, pc
    );
endinterface

// File: rtl/proc_din_sequencer.sv
// Feeds a loadable program to the lab9 processor over DIN/Run/Done, one instruction per Done.
// Define SEQ_TIMEOUT_EN to add a 63-cycle WAIT watchdog that halts with Error.
module proc_din_sequencer #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AW        = 5,
    parameter logic [8:0]  HALT_WORD = 9'h1FF
) (
    input logic                   Clock,
    input logic                   Resetn,
    proc_din_sequencer_if.master  bus
);
    localparam logic [2:0]  OP_MVI  = 3'b001;
    localparam logic [AW:0] END_PC  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_PC = (AW+1)'(DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DATA, S_WAIT, S_HALT} state_t;

    state_t      state;
    logic [8:0]  mem [DEPTH];
    logic [8:0]  din_q;
    logic        run_q;
    logic        busy_q;
    logic        halted_q;
    logic        error_q;
    logic [AW:0] pc_q;
`ifdef SEQ_TIMEOUT_EN
    logic [5:0]  wdog;
`endif

    logic [AW:0] disp_pc;
    logic [AW:0] pc_inc1;
    logic [AW:0] pc_inc2;
    logic [8:0]  disp_word;
    logic        disp_end;
    logic        disp_err;
    logic        disp_stop;
    logic        do_dispatch;

    // Dispatch looks at the word at pc (after Done) or at address 0 (after Start).
    always_comb begin
        disp_pc     = (state == S_WAIT) ? pc_q : '0;
        disp_end    = (disp_pc == END_PC);
        disp_word   = mem[disp_pc[AW-1:0]];
        disp_err    = !disp_end && (disp_word != HALT_WORD) &&
                      (disp_word[8:6] == OP_MVI) && (disp_pc == LAST_PC);
        disp_stop   = disp_end || (disp_word == HALT_WORD) || disp_err;
        pc_inc1     = pc_q + (AW+1)'(1);
        pc_inc2     = pc_q + (AW+1)'(2);
        do_dispatch = (((state == S_IDLE) || (state == S_HALT)) && bus.Start) ||
                      ((state == S_WAIT) && bus.Done);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            din_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            pc_q     <= '0;
`ifdef SEQ_TIMEOUT_EN
            wdog     <= '0;
`endif
        end else if (do_dispatch) begin
            pc_q <= disp_pc;
`ifdef SEQ_TIMEOUT_EN
            wdog <= '0;
`endif
            if (disp_stop) begin
                state    <= S_HALT;
                din_q    <= '0;
                run_q    <= 1'b0;
                busy_q   <= 1'b0;
                halted_q <= 1'b1;
                error_q  <= disp_err;
            end else begin
                state    <= S_ISSUE;
                din_q    <= disp_word;
                run_q    <= 1'b1;
                busy_q   <= 1'b1;
                halted_q <= 1'b0;
                error_q  <= 1'b0;
            end
        end else begin
            case (state)
                S_ISSUE: begin
                    run_q <= 1'b0;
                    if (din_q[8:6] == OP_MVI) begin
                        state <= S_DATA;
                        din_q <= mem[pc_inc1[AW-1:0]];
                    end else begin
                        state <= S_WAIT;
                        pc_q  <= pc_inc1;
                    end
                end
                S_DATA: begin
                    state <= S_WAIT;
                    pc_q  <= pc_inc2;
                end
                S_WAIT: begin
`ifdef SEQ_TIMEOUT_EN
                    // Reaching 62 here means this is the 63rd WAIT cycle without Done.
                    if (wdog == 6'd62) begin
                        state    <= S_HALT;
                        din_q    <= '0;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        error_q  <= 1'b1;
                        wdog     <= '0;
                    end else begin
                        wdog <= wdog + 6'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (bus.ld_we && !busy_q)
            mem[bus.ld_addr] <= bus.ld_data;
    end

    assign bus.DIN    = din_q;
    assign bus.Run    = run_q;
    assign bus.Busy   = busy_q;
    assign bus.Halted = halted_q;
    assign bus.Error  = error_q;
    assign bus.pc     = pc_q;
endmodule
